// File: rtl/hamming_tx_serializer_if.sv
// hamming_tx_serializer_if: codeword handshake and serial line bundle between
// hamming_encoder (master) and hamming_tx_serializer (slave).
interface hamming_tx_serializer_if;
    logic [11:0] code_in;
    logic        code_valid;
    logic        code_ready;
    logic        tx_out;
    logic        busy;
    logic        frame_done;
    modport master (output code_in, code_valid, input code_ready, tx_out, busy, frame_done);
    modport slave (input code_in, code_valid, output code_ready, tx_out, busy, frame_done);
endinterface

// File: rtl/hamming_tx_serializer.sv
// hamming_tx_serializer: shifts one 12-bit codeword per handshake out as a start/data/stop frame.
// Define HAM_TX_PARITY_EN to insert an even-parity bit between data and stop.
module hamming_tx_serializer #(
    parameter int CLKS_PER_BIT = 4,
    parameter int CODE_W       = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    hamming_tx_serializer_if.slave  bus
);
    localparam int              PW       = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [PW-1:0]   LAST_CNT = PW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]      LAST_BIT = 4'(CODE_W - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP
`ifdef HAM_TX_PARITY_EN
        , PARITY
`endif
    } state_t;

`ifdef HAM_TX_PARITY_EN
    localparam state_t AFTER_DATA = PARITY;
`else
    localparam state_t AFTER_DATA = STOP;
`endif

    state_t              r_state, w_state_n;
    logic [PW-1:0]       r_cnt, w_cnt_n;
    logic [3:0]          r_bit, w_bit_n;
    logic [CODE_W-1:0]   r_shift, w_shift_n;
    logic                r_tx, w_tx_n;
    logic                r_done, w_done_n;
    logic                w_last;

    assign w_last         = r_cnt == LAST_CNT;
    assign bus.code_ready = r_state == IDLE;
    assign bus.busy       = r_state != IDLE;
    assign bus.tx_out     = r_tx;
    assign bus.frame_done = r_done;

`ifdef HAM_TX_PARITY_EN
    logic r_par;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_par <= 1'b0;
        else if (r_state == IDLE && bus.code_valid)
            r_par <= ^bus.code_in;
    end
`endif

    // Outputs are computed from the next state so the line tracks the FSM without lag.
    always_comb begin
        w_state_n = r_state;
        w_bit_n   = r_bit;
        w_shift_n = r_shift;
        w_cnt_n   = (r_state == IDLE || w_last) ? '0 : r_cnt + 1'b1;
        case (r_state)
            IDLE: if (bus.code_valid) begin
                w_state_n = START;
                w_shift_n = bus.code_in;
            end
            START: if (w_last) w_state_n = DATA;
            DATA: if (w_last) begin
                w_shift_n = r_shift >> 1;
                w_bit_n   = (r_bit == LAST_BIT) ? '0 : r_bit + 1'b1;
                w_state_n = (r_bit == LAST_BIT) ? AFTER_DATA : DATA;
            end
`ifdef HAM_TX_PARITY_EN
            PARITY: if (w_last) w_state_n = STOP;
`endif
            STOP: if (w_last) w_state_n = IDLE;
            default: w_state_n = IDLE;
        endcase
        w_tx_n = w_state_n == START ? 1'b0 : w_state_n == DATA ? w_shift_n[0] : 1'b1;
`ifdef HAM_TX_PARITY_EN
        if (w_state_n == PARITY) w_tx_n = r_par;
`endif
        w_done_n = w_state_n == STOP && w_cnt_n == LAST_CNT;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_bit   <= w_bit_n;
            r_shift <= w_shift_n;
            r_tx    <= w_tx_n;
            r_done  <= w_done_n;
        end
    end
endmodule

// File: tb/tb_hamming_tx_serializer.sv
// tb_hamming_tx_serializer: directed frame checks at CLKS_PER_BIT of 4, 1 and 2.
// Cycle k is the k-th clock after the transfer edge; outputs sampled on falling edges.
module tb_hamming_tx_serializer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hamming_tx_serializer_if a ();
    hamming_tx_serializer_if b ();
    hamming_tx_serializer_if c ();

    hamming_tx_serializer #(.CLKS_PER_BIT(4)) u_a (.clk(clk), .rst(rst), .bus(a.slave));
    hamming_tx_serializer #(.CLKS_PER_BIT(1)) u_b (.clk(clk), .rst(rst), .bus(b.slave));
    hamming_tx_serializer #(.CLKS_PER_BIT(2)) u_c (.clk(clk), .rst(rst), .bus(c.slave));

    int   n_tests = 0;
    int   n_fail  = 0;
    logic cap_tx [0:127];
    logic cap_done [0:127];
    logic cap_rdy [0:127];
    logic cap_busy [0:127];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int sel, input logic [11:0] code, input logic vld);
        if (sel == 0) begin a.code_in = code; a.code_valid = vld; end
        else if (sel == 1) begin b.code_in = code; b.code_valid = vld; end
        else begin c.code_in = code; c.code_valid = vld; end
    endtask

    // Starts on a falling edge (cycle 0) with the DUT idle; captures cycles 1..ncyc.
    task automatic send(input int sel, input logic [11:0] code, input int ncyc, input bit hold);
        drive(sel, code, 1'b1);
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            cap_tx[k]   = sel == 0 ? a.tx_out     : sel == 1 ? b.tx_out     : c.tx_out;
            cap_done[k] = sel == 0 ? a.frame_done : sel == 1 ? b.frame_done : c.frame_done;
            cap_rdy[k]  = sel == 0 ? a.code_ready : sel == 1 ? b.code_ready : c.code_ready;
            cap_busy[k] = sel == 0 ? a.busy       : sel == 1 ? b.busy       : c.busy;
            if (!hold && k == 1) drive(sel, code, 1'b0);
            if (hold && k == 10) drive(sel, 12'hFFF, 1'b1);
            if (hold && k == 50) drive(sel, 12'hF0F, 1'b1);
            if (hold && k == 58) drive(sel, 12'hF0F, 1'b0);
        end
    endtask

    function automatic logic [11:0] get_data(input int first, input int step);
        logic [11:0] d;
        for (int i = 0; i < 12; i++) d[i] = cap_tx[first + step * i];
        return d;
    endfunction

    function automatic logic [11:0] enc(input logic [7:0] d);
        logic [11:0] cw;
        int j;
        cw = '0;
        j  = 0;
        for (int p = 1; p <= 12; p++)
            if ((p & (p - 1)) != 0) begin cw[p-1] = d[j]; j++; end
        for (int k = 0; k < 4; k++)
            for (int p = 1; p <= 12; p++)
                if (p != (1 << k) && ((p >> k) & 1) == 1) cw[(1 << k) - 1] ^= cw[p-1];
        return cw;
    endfunction

    // Returns {error, corrected data}.
    function automatic logic [8:0] dec(input logic [11:0] cw_in);
        logic [11:0] cw;
        logic [7:0]  d;
        int syn, j;
        cw  = cw_in;
        syn = 0;
        for (int p = 1; p <= 12; p++) if (cw[p-1]) syn ^= p;
        if (syn >= 1 && syn <= 12) cw[syn-1] = ~cw[syn-1];
        j = 0;
        d = '0;
        for (int p = 1; p <= 12; p++)
            if ((p & (p - 1)) != 0) begin d[j] = cw[p-1]; j++; end
        return {syn != 0, d};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] got, exp;
        logic [11:0] cw;
        logic [8:0]  rx;
        rst = 1'b1;
        drive(0, 12'h000, 1'b0);
        drive(1, 12'h000, 1'b0);
        drive(2, 12'h000, 1'b0);
        #12;
        check("rst_tx", a.tx_out, 1);
        check("rst_ready", a.code_ready, 1);
        check("rst_busy", a.busy, 0);
        check("rst_done", a.frame_done, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Single frame, 4 clocks per bit
        send(0, 12'h001, 57, 1'b0);
        got = '0; exp = '0;
        for (int k = 1; k <= 56; k++) begin
            got[k-1] = cap_tx[k];
            exp[k-1] = (k >= 5 && k <= 8) || k >= 53;
        end
        check("t1_tx_seq", got, exp);
        got = '0;
        for (int k = 1; k <= 57; k++) got[k-1] = cap_done[k];
        check("t1_done_seq", got, 64'h1 << 55);
        check("t1_ready56", cap_rdy[56], 0);
        check("t1_busy56", cap_busy[56], 1);
        check("t1_ready57", cap_rdy[57], 1);
        check("t1_busy57", cap_busy[57], 0);

        // One clock per bit
        send(1, 12'hA5C, 15, 1'b0);
        got = '0;
        for (int k = 1; k <= 14; k++) got[k-1] = cap_tx[k];
        check("t2_tx_seq", got, 64'b11010010111000);
        check("t2_data", get_data(2, 1), 12'hA5C);
        check("t2_done13", cap_done[13], 0);
        check("t2_done14", cap_done[14], 1);
        check("t2_ready15", cap_rdy[15], 1);

        // Back-to-back with code_valid held and code_in changed mid-frame
        send(0, 12'h0F0, 114, 1'b1);
        check("t3_data1", get_data(5, 4), 12'h0F0);
        check("t3_done56", cap_done[56], 1);
        check("t3_ready57", cap_rdy[57], 1);
        check("t3_gap_tx57", cap_tx[57], 1);
        check("t3_start58", cap_tx[58], 0);
        check("t3_data2", get_data(62, 4), 12'hF0F);
        check("t3_done113", cap_done[113], 1);
        check("t3_idle114", {cap_tx[114], cap_done[114], cap_rdy[114]}, 3'b101);

        // Reset during data bit 5
        send(0, 12'h0F0, 26, 1'b0);
        rst = 1'b1;
        #1;
        check("t4_rst_tx", a.tx_out, 1);
        check("t4_rst_busy", a.busy, 0);
        check("t4_rst_ready", a.code_ready, 1);
        check("t4_rst_done", a.frame_done, 0);
        @(negedge clk);
        rst = 1'b0;
        got = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            got[k] = a.frame_done | a.busy | ~a.tx_out;
        end
        check("t4_quiet", got, 0);
        send(0, 12'h3C3, 57, 1'b0);
        check("t4_start", cap_tx[4], 0);
        check("t4_data", get_data(5, 4), 12'h3C3);
        check("t4_done56", cap_done[56], 1);

`ifdef HAM_TX_PARITY_EN
        send(2, 12'h001, 31, 1'b0);
        check("t5_data", get_data(3, 2), 12'h001);
        check("t5_par_001", {cap_tx[27], cap_tx[28]}, 2'b11);
        check("t5_done29", cap_done[29], 0);
        check("t5_done30", cap_done[30], 1);
        check("t5_ready31", cap_rdy[31], 1);
        send(2, 12'h003, 31, 1'b0);
        check("t5_par_003", {cap_tx[27], cap_tx[28]}, 2'b00);
        check("t5_stop_003", cap_tx[29], 1);
        check("t5_done30b", cap_done[30], 1);
`else
        send(2, 12'h001, 29, 1'b0);
        check("t5_data", get_data(3, 2), 12'h001);
        check("t5_stop27", cap_tx[27], 1);
        check("t5_done27", cap_done[27], 0);
        check("t5_done28", cap_done[28], 1);
        check("t5_ready29", cap_rdy[29], 1);
        cw = enc(8'hA7);
        send(2, cw, 29, 1'b0);
        check("t6_rx_code", get_data(3, 2), cw);
        rx = dec(get_data(3, 2));
        check("t6_clean", rx, {1'b0, 8'hA7});
        rx = dec(get_data(3, 2) ^ 12'h020);
        check("t6_corrected", rx, {1'b1, 8'hA7});
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
